// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch FSM with request/ack memory reads, a 2-entry
// prefetch queue toward the decoder, flush and a sticky timeout fault.
module instr_fetch #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [ADDR_W-1:0] pcAddress,
    output logic              pcOutEn,
    output logic              pcCount,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRd,
    input  logic [DATA_W-1:0] memData,
    input  logic              memAck,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic [11:0]       operand,
    output logic              irValid,
    input  logic              irReady,
    output logic              fetchFault
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] INC   = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] q0_q, q0_d, q1_q, q1_d;
    logic              push, pop;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE:    state_d = (!stall && !flush && count_q != 2'd2) ? ADDR : IDLE;
            ADDR: begin
                state_d = flush ? IDLE : READ;
                addr_d  = flush ? addr_q : pcAddress;
                tmo_d   = '0;
            end
            // An ack wins over flush: the word has already left memory, so the PC must still advance
            READ: begin
                if (memAck)
                    state_d = INC;
                else if (flush)
                    state_d = IDLE;
                else if (tmo_q == TW'(TIMEOUT - 1))
                    state_d = FAULT;
                else
                    tmo_d = tmo_q + 1'b1;
            end
            INC:     state_d = IDLE;
            FAULT:   state_d = flush ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
    end

    assign push = state_q == READ && memAck && !flush;
    assign pop  = count_q != 2'd0 && irReady && !flush;

    always_comb begin
        q0_d    = q0_q;
        q1_d    = q1_q;
        count_d = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
        if (pop) begin
            q0_d = (push && count_q == 2'd1) ? memData : q1_q;
            q1_d = push ? memData : q1_q;
        end else if (push) begin
            q0_d = (count_q == 2'd0) ? memData : q0_q;
            q1_d = (count_q == 2'd0) ? q1_q : memData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            addr_q  <= '0;
            count_q <= 2'd0;
            q0_q    <= '0;
            q1_q    <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
        end
    end

    assign pcOutEn    = state_q == ADDR;
    assign memRd      = state_q == READ;
    assign pcCount    = state_q == INC;
    assign fetchFault = state_q == FAULT;
    assign memAddr    = addr_q;
    assign irValid    = count_q != 2'd0;
    assign instr      = q0_q;
    assign opcode     = q0_q[15:12];
    assign operand    = q0_q[11:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus, a cycle model of the fetch stage
// checked on every cycle, plus literal checkpoints per scenario.
module tb_instr_fetch;
    localparam int TIMEOUT = 15;

    logic        clk = 0;
    logic        resetN = 0;
    logic [15:0] pcAddress = 0;
    logic [15:0] memData = 0;
    logic        memAck = 0, stall = 0, flush = 0, irReady = 0;
    logic        pcOutEn, pcCount, memRd, irValid, fetchFault;
    logic [15:0] memAddr, instr;
    logic [3:0]  opcode;
    logic [11:0] operand;

    int n_tests = 0, n_fail = 0;
    int n_a = 0, n_p = 0, n_r = 0;

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetN(resetN), .pcAddress(pcAddress), .pcOutEn(pcOutEn),
        .pcCount(pcCount), .memAddr(memAddr), .memRd(memRd), .memData(memData),
        .memAck(memAck), .stall(stall), .flush(flush), .instr(instr),
        .opcode(opcode), .operand(operand), .irValid(irValid), .irReady(irReady),
        .fetchFault(fetchFault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: queue of words, plus which step of a fetch the engine is in
    logic [15:0] mq[$];
    logic [15:0] m_addr, head;
    int          m_age, nage, sz;
    bit          m_a, m_p, m_f, na, np;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mq.delete();
            m_age = -1; m_a = 0; m_p = 0; m_f = 0; m_addr = 0;
        end else begin
            sz = mq.size(); na = 0; np = 0; nage = -1;
            if (sz > 0 && irReady) void'(mq.pop_front());
            if (flush) mq.delete();
            if (!m_p) begin
                if (m_a) begin
                    if (!flush) begin m_addr = pcAddress; nage = 0; end
                end else if (m_age >= 0) begin
                    if (memAck) begin
                        np = 1;
                        if (!flush) mq.push_back(memData);
                    end else if (!flush) begin
                        if (m_age + 1 == TIMEOUT) m_f = 1; else nage = m_age + 1;
                    end
                end else if (m_f) begin
                    if (flush) m_f = 0;
                end else
                    na = !stall && !flush && sz < 2;
            end
            m_a = na; m_p = np; m_age = nage;
        end
    end

    always @(negedge clk) begin
        if (resetN) begin
            chk("pcOutEn", pcOutEn, m_a);
            chk("memRd", memRd, m_age >= 0);
            chk("pcCount", pcCount, m_p);
            chk("fetchFault", fetchFault, m_f);
            chk("memAddr", memAddr, m_addr);
            chk("irValid", irValid, mq.size() > 0);
            if (mq.size() > 0) begin
                head = mq[0];
                chk("instr", instr, head);
                chk("opcode", opcode, head[15:12]);
                chk("operand", operand, head[11:0]);
            end
        end
    end

    always @(negedge clk) begin
        n_a <= n_a + int'(pcOutEn);
        n_p <= n_p + int'(pcCount);
        n_r <= n_r + int'(memRd);
    end

    task automatic wait_rd();
        for (int i = 0; i < 50 && !memRd; i++) @(negedge clk);
        chk("rd_seen", memRd, 1);
    endtask

    task automatic fetch_word(input logic [15:0] d);
        wait_rd();
        memData = d; memAck = 1;
        @(negedge clk);
        memAck = 0;
    endtask

    int s0, s1, s2;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_irValid", irValid, 0);
        chk("rst_memRd", memRd, 0);
        chk("rst_pcOutEn", pcOutEn, 0);
        chk("rst_pcCount", pcCount, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_fault", fetchFault, 0);
        chk("rst_instr", instr, 0);
        resetN = 1;
        // single fetch, ack on first READ cycle
        fetch_word(16'hA123);
        stall = 1;
        repeat (2) @(negedge clk);
        chk("t1_irValid", irValid, 1);
        chk("t1_opcode", opcode, 4'hA);
        chk("t1_operand", operand, 12'h123);
        chk("t1_memAddr", memAddr, 16'h0000);
        chk("t1_pulses", n_p, 1);
        // fill the queue, no fetch while full
        flush = 1; @(negedge clk); flush = 0;
        pcAddress = 16'h0010; stall = 0;
        fetch_word(16'h1111);
        pcAddress = 16'h0011;
        fetch_word(16'h2222);
        s0 = n_a;
        repeat (5) @(negedge clk);
        chk("t2_no_addr", n_a - s0, 0);
        chk("t2_head", instr, 16'h1111);
        chk("t2_memAddr", memAddr, 16'h0011);
        irReady = 1; @(negedge clk); irReady = 0;
        chk("t2_pop", instr, 16'h2222);
        @(negedge clk);
        chk("t2_refetch", pcOutEn, 1);
        // push and pop together
        pcAddress = 16'h0012;
        wait_rd();
        memData = 16'h3333; memAck = 1; irReady = 1; stall = 1;
        @(negedge clk);
        memAck = 0; irReady = 0;
        chk("t3_valid", irValid, 1);
        chk("t3_instr", instr, 16'h3333);
        irReady = 1; @(negedge clk); irReady = 0;
        chk("t3_empty", irValid, 0);
        // timeout fault
        s0 = n_r; stall = 0;
        for (int i = 0; i < 60 && !fetchFault; i++) @(negedge clk);
        chk("t4_fault", fetchFault, 1);
        chk("t4_rd_cycles", n_r - s0, TIMEOUT);
        chk("t4_rd_low", memRd, 0);
        flush = 1; @(negedge clk); flush = 0;
        chk("t4_cleared", fetchFault, 0);
        fetch_word(16'h4444);
        stall = 1;
        repeat (2) @(negedge clk);
        chk("t4_resume", instr, 16'h4444);
        // flush together with ack
        flush = 1; @(negedge clk); flush = 0;
        s0 = n_p; stall = 0;
        wait_rd();
        memData = 16'h5555; memAck = 1; flush = 1; stall = 1;
        @(negedge clk);
        memAck = 0; flush = 0;
        chk("t5_pulse", pcCount, 1);
        chk("t5_discard", irValid, 0);
        repeat (3) @(negedge clk);
        chk("t5_one_pulse", n_p - s0, 1);
        // stall holds off fetching
        s0 = n_a; s1 = n_r; s2 = n_p;
        repeat (10) @(negedge clk);
        chk("t6_no_addr", n_a - s0, 0);
        chk("t6_no_rd", n_r - s1, 0);
        chk("t6_no_pulse", n_p - s2, 0);
        stall = 0;
        @(negedge clk);
        chk("t6_addr_next", pcOutEn, 1);
        // async reset mid-READ
        @(negedge clk);
        chk("t7_reading", memRd, 1);
        #2 resetN = 0;
        #1;
        chk("t7_rd_drop", memRd, 0);
        chk("t7_no_pulse", pcCount, 0);
        chk("t7_empty", irValid, 0);
        @(negedge clk);
        resetN = 1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
